multicycle_alu: RTL
===================

# multicycle_alu

Parametrised, handshaked successor to the two-phase ALU of the Harvard machine core. It sits between the sequencer and the accumulator/PC/data-memory/7-segment paths, on the same control bus. Each operation runs only after a start strobe. DIV/MOD use an iterative DATA_W-cycle restoring divider. Every destination gets an explicit one-cycle write strobe, so no register is updated by an implicit latch.

## Interface
- DATA_W, 16, datapath width (accumulator, memory data, result); ≥ 4
- PC_W, 8, program-counter width; ≤ DATA_W
- clkInput  in  1  single clock, all state on rising edge
- rstNInput  in  1  asynchronous, active-low reset
- StartInput  in  1  start strobe; sampled only in IDLE
- OperandInput  in  5  opcode, same encoding as the current core
- OutputSelectorInput  in  3  destination: 000 none, 001 ACC, 010 PC, 011 memory, 100 7-seg, others none
- ConditionFlagReadInput  in  1  current condition flag
- AccumulatorReadInput  in  DATA_W  A operand
- DataReadInput  in  DATA_W  B operand
- BusyOutput  out  1  high from the start-accept edge until Done
- DoneOutput  out  1  one-cycle completion pulse
- ConditionFlagWriteOutput  out  1  registered condition flag
- EndFlagWriteOutput  out  1  sticky end-of-program flag
- DivideByZeroOutput  out  1  set by DIV/MOD with B=0; cleared at the next accepted start
- ProgramCounterOutput / ProgramCounterWriteOutput  out  PC_W / 1  PC value / write strobe
- AccumulatorWriteOutput / AccumulatorWriteEnableOutput  out  DATA_W / 1  ACC value / write strobe
- DataWriteOutput / DataWriteEnableOutput  out  DATA_W / 1  memory value / write strobe
- OutputBinaryOutput / OutputBinaryWriteOutput  out  DATA_W / 1  7-seg value / write strobe

## Operation
- States: IDLE, CALC, DIVIDE, WRITE.
- IDLE: when StartInput=1, latch opcode, selector, both operands and the condition-flag input, clear DivideByZero, and go to CALC. StartInput in any other state is ignored (not queued).
- CALC: evaluate the latched operands into a DATA_W result register.
  - DIV/MOD with B≠0: load the divider and go to DIVIDE.
  - All other cases: go to WRITE.
- Opcodes and results:
  - NOP 00000: result 0.
  - PRINT 00001, STORE 00011, JUMP 01100: result B.
  - LOAD 00010: result A.
  - EOP 00100: EndFlag set to 1; sticky until reset.
  - LT 01000 / GT 01001: flag = signed(A) < signed(B) / signed(A) > signed(B).
  - BEQ 01101 / BNE 01110: result B; taken iff latched flag = 1 / 0.
  - ADD 10000 / SUB 10001: A+B / A−B, modulo 2^DATA_W.
  - MUL 10010: low DATA_W bits of the unsigned product.
  - DIV 10011 / MOD 10100: unsigned quotient / remainder.
  - NOT 10101: ~A.
  - OR 10110: A|B.
  - AND 10111: A&B.
  - Undefined opcodes: result 0, no flag change.
- Condition flag changes only on LT/GT. All other opcodes hold it.
- Divide by zero: quotient all-ones, remainder = A, DivideByZero=1, DIVIDE state skipped.
- DIVIDE: one quotient bit per cycle, MSB first, for exactly DATA_W cycles, then go to WRITE.
- WRITE:
  - Register the result into the selected destination's value output and pulse that destination's strobe for one cycle.
  - PC receives result[PC_W-1:0].
  - For BEQ/BNE not taken, or selector none, no strobe fires.
  - Pulse DoneOutput, then go to IDLE.
- Value outputs of non-selected destinations hold their previous values.

## Timing
- Reset (asynchronous assert, synchronous-safe release):
  - State returns to IDLE.
  - Every output is 0.
  - Any in-flight operation is abandoned with no strobe or Done.
- Start accepted at edge k:
  - BusyOutput goes high after edge k.
  - Non-divide ops: result written at edge k+2; DoneOutput, the strobe and the new value are visible in cycle k+2 to k+3.
  - DIV/MOD with B≠0: Done after edge k+2+DATA_W.
  - DIV/MOD with B=0: Done after edge k+2.
- BusyOutput drops in the same cycle Done is high. A new start can be accepted at the edge ending the Done cycle.
- Strobes and DoneOutput are exactly one cycle wide.
- The flag and EndFlag are updated at the CALC edge (k+1).
- Operand inputs may change freely after edge k.

## Test plan
- Reset mid-DIVIDE (rstNInput low at cycle k+5) -> all outputs 0, no Done; a new start afterwards completes normally.
- ADD, A=16'h7FFF, B=1, selector ACC -> AccumulatorWriteOutput=16'h8000 with enable pulsed in cycle k+2; Busy high for 2 cycles.
- DIV, A=100, B=7, selector ACC, DATA_W=16 -> 14 after 18 cycles; MOD with the same operands, selector memory -> DataWriteOutput=2.
- DIV, B=0 -> ACC=16'hFFFF, DivideByZeroOutput=1, Done at k+2; the next start clears it.
- LT, A=16'hFFFF (−1), B=1 -> flag=1. Then BNE, B=8'h3C, selector PC -> no PC strobe. Then BEQ -> ProgramCounterOutput=8'h3C with strobe.
- StartInput held high through a MUL, A=300, B=300 -> 16'h5F90; exactly one Done per accepted start, restart on the Done-cycle edge. EOP -> EndFlag stays 1 across later ops until reset.

Source files
------------

// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - handshaked multicycle ALU with iterative restoring divider
module multicycle_alu #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 8
) (
    input  logic              clkInput,
    input  logic              rstNInput,
    input  logic              StartInput,
    input  logic [4:0]        OperandInput,
    input  logic [2:0]        OutputSelectorInput,
    input  logic              ConditionFlagReadInput,
    input  logic [DATA_W-1:0] AccumulatorReadInput,
    input  logic [DATA_W-1:0] DataReadInput,
    output logic              BusyOutput,
    output logic              DoneOutput,
    output logic              ConditionFlagWriteOutput,
    output logic              EndFlagWriteOutput,
    output logic              DivideByZeroOutput,
    output logic [PC_W-1:0]   ProgramCounterOutput,
    output logic              ProgramCounterWriteOutput,
    output logic [DATA_W-1:0] AccumulatorWriteOutput,
    output logic              AccumulatorWriteEnableOutput,
    output logic [DATA_W-1:0] DataWriteOutput,
    output logic              DataWriteEnableOutput,
    output logic [DATA_W-1:0] OutputBinaryOutput,
    output logic              OutputBinaryWriteOutput
);

    localparam logic [4:0] OpNop   = 5'b00000;
    localparam logic [4:0] OpPrint = 5'b00001;
    localparam logic [4:0] OpLoad  = 5'b00010;
    localparam logic [4:0] OpStore = 5'b00011;
    localparam logic [4:0] OpEop   = 5'b00100;
    localparam logic [4:0] OpLt    = 5'b01000;
    localparam logic [4:0] OpGt    = 5'b01001;
    localparam logic [4:0] OpJump  = 5'b01100;
    localparam logic [4:0] OpBeq   = 5'b01101;
    localparam logic [4:0] OpBne   = 5'b01110;
    localparam logic [4:0] OpAdd   = 5'b10000;
    localparam logic [4:0] OpSub   = 5'b10001;
    localparam logic [4:0] OpMul   = 5'b10010;
    localparam logic [4:0] OpDiv   = 5'b10011;
    localparam logic [4:0] OpMod   = 5'b10100;
    localparam logic [4:0] OpNot   = 5'b10101;
    localparam logic [4:0] OpOr    = 5'b10110;
    localparam logic [4:0] OpAnd   = 5'b10111;

    localparam int            CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] DivLast = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StCalc   = 2'd1,
        StDivide = 2'd2,
        StWrite  = 2'd3
    } aluStateT;

    aluStateT          stateReg;
    aluStateT          stateNext;

    logic [4:0]        opReg;
    logic [2:0]        selReg;
    logic [DATA_W-1:0] aReg;
    logic [DATA_W-1:0] bReg;
    logic              flagLatch;
    logic [DATA_W-1:0] resultReg;
    logic [DATA_W-1:0] calcResult;

    logic [DATA_W:0]   remReg;
    logic [DATA_W-1:0] quoReg;
    logic [CNT_W-1:0]  divCount;
    logic [DATA_W:0]   remShifted;
    logic [DATA_W:0]   remTrial;
    logic [DATA_W:0]   remNext;
    logic [DATA_W-1:0] quoNext;

    logic              startAccept;
    logic              isDivOp;
    logic              bIsZero;
    logic              branchBlocked;

    assign startAccept   = (stateReg == StIdle) && StartInput;
    assign isDivOp       = (opReg == OpDiv) || (opReg == OpMod);
    assign bIsZero       = (bReg == '0);
    assign branchBlocked = ((opReg == OpBeq) && !flagLatch) || ((opReg == OpBne) && flagLatch);
    assign BusyOutput    = (stateReg != StIdle);

    // State register
    always_ff @(posedge clkInput or negedge rstNInput) begin
        if (!rstNInput) begin
            stateReg <= StIdle;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Next-state sequencing: divide path only when a nonzero divisor needs iterating
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            StIdle:   if (StartInput) stateNext = StCalc;
            StCalc:   stateNext = (isDivOp && !bIsZero) ? StDivide : StWrite;
            StDivide: if (divCount == DivLast) stateNext = StWrite;
            StWrite:  stateNext = StIdle;
            default:  stateNext = StIdle;
        endcase
    end

    // Single-cycle result; divide-by-zero results are the final values
    always_comb begin
        calcResult = '0;
        case (opReg)
            OpPrint, OpStore, OpJump, OpBeq, OpBne: calcResult = bReg;
            OpLoad:  calcResult = aReg;
            OpAdd:   calcResult = aReg + bReg;
            OpSub:   calcResult = aReg - bReg;
            OpMul:   calcResult = aReg * bReg;
            OpDiv:   calcResult = '1;
            OpMod:   calcResult = aReg;
            OpNot:   calcResult = ~aReg;
            OpOr:    calcResult = aReg | bReg;
            OpAnd:   calcResult = aReg & bReg;
            default: calcResult = '0;
        endcase
    end

    // One restoring-divider step: shift in the next dividend bit and try to subtract
    always_comb begin
        remShifted = {remReg[DATA_W-1:0], quoReg[DATA_W-1]};
        remTrial   = remShifted - {1'b0, bReg};
        if (!remTrial[DATA_W]) begin
            remNext = remTrial;
            quoNext = {quoReg[DATA_W-2:0], 1'b1};
        end else begin
            remNext = remShifted;
            quoNext = {quoReg[DATA_W-2:0], 1'b0};
        end
    end

    // Operand latch, flags and result register
    always_ff @(posedge clkInput or negedge rstNInput) begin
        if (!rstNInput) begin
            opReg                    <= OpNop;
            selReg                   <= '0;
            aReg                     <= '0;
            bReg                     <= '0;
            flagLatch                <= 1'b0;
            resultReg                <= '0;
            ConditionFlagWriteOutput <= 1'b0;
            EndFlagWriteOutput       <= 1'b0;
            DivideByZeroOutput       <= 1'b0;
        end else if (startAccept) begin
            opReg              <= OperandInput;
            selReg             <= OutputSelectorInput;
            aReg               <= AccumulatorReadInput;
            bReg               <= DataReadInput;
            flagLatch          <= ConditionFlagReadInput;
            DivideByZeroOutput <= 1'b0;
        end else if (stateReg == StCalc) begin
            resultReg <= calcResult;
            if (opReg == OpLt) ConditionFlagWriteOutput <= ($signed(aReg) < $signed(bReg));
            if (opReg == OpGt) ConditionFlagWriteOutput <= ($signed(aReg) > $signed(bReg));
            if (opReg == OpEop) EndFlagWriteOutput <= 1'b1;
            if (isDivOp && bIsZero) DivideByZeroOutput <= 1'b1;
        end else if (stateReg == StDivide) begin
            resultReg <= (opReg == OpDiv) ? quoNext : remNext[DATA_W-1:0];
        end
    end

    // Divider registers: seeded in CALC, one quotient bit per DIVIDE cycle
    always_ff @(posedge clkInput or negedge rstNInput) begin
        if (!rstNInput) begin
            remReg   <= '0;
            quoReg   <= '0;
            divCount <= '0;
        end else if (stateReg == StCalc) begin
            remReg   <= '0;
            quoReg   <= aReg;
            divCount <= '0;
        end else if (stateReg == StDivide) begin
            remReg   <= remNext;
            quoReg   <= quoNext;
            divCount <= divCount + 1'b1;
        end
    end

    // Destination write-back with single-cycle strobes and Done
    always_ff @(posedge clkInput or negedge rstNInput) begin
        if (!rstNInput) begin
            DoneOutput                   <= 1'b0;
            ProgramCounterOutput         <= '0;
            ProgramCounterWriteOutput    <= 1'b0;
            AccumulatorWriteOutput       <= '0;
            AccumulatorWriteEnableOutput <= 1'b0;
            DataWriteOutput              <= '0;
            DataWriteEnableOutput        <= 1'b0;
            OutputBinaryOutput           <= '0;
            OutputBinaryWriteOutput      <= 1'b0;
        end else begin
            DoneOutput                   <= 1'b0;
            ProgramCounterWriteOutput    <= 1'b0;
            AccumulatorWriteEnableOutput <= 1'b0;
            DataWriteEnableOutput        <= 1'b0;
            OutputBinaryWriteOutput      <= 1'b0;
            if (stateReg == StWrite) begin
                DoneOutput <= 1'b1;
                if (!branchBlocked) begin
                    case (selReg)
                        3'b001: begin
                            AccumulatorWriteOutput       <= resultReg;
                            AccumulatorWriteEnableOutput <= 1'b1;
                        end
                        3'b010: begin
                            ProgramCounterOutput      <= resultReg[PC_W-1:0];
                            ProgramCounterWriteOutput <= 1'b1;
                        end
                        3'b011: begin
                            DataWriteOutput       <= resultReg;
                            DataWriteEnableOutput <= 1'b1;
                        end
                        3'b100: begin
                            OutputBinaryOutput      <= resultReg;
                            OutputBinaryWriteOutput <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
